// File: rtl/tqvp_dlmiles_i2c_bitseq.sv
// I2C bit-level sequencer: START, STOP and single data bits
// on open-drain SCL/SDA, paced by an external phase timer.
module tqvp_dlmiles_i2c_bitseq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       wdata_i,
  output logic       done_o,
  output logic       rdata_o,
  output logic       err_o,
  output logic       arb_lost_o,
  output logic       busy_o,
  output logic       timer_run_o,
  output logic       timer_clear_o,
  input  logic       stb_prewait_i,
  input  logic       stb_scllow_i,
  input  logic       stb_sclhigh_i,
  input  logic       stb_overflow_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    RS_REL,
    RS_SETUP,
    ST_HOLD,
    ST_LOW,
    BIT_LOW,
    BIT_HIGH,
    SP_LOW,
    SP_SETUP,
    SP_FREE
  } state_t;

  state_t state;
  logic   owned;
  logic   is_write;
  logic   wbit;
  logic   accept;
  logic   live;
  logic   prewait;
  logic   scllow;
  logic   sclhigh;
  logic   ovf;
  logic   stretch;

  assign cmd_ready_o = (state == IDLE) && !rst;
  assign busy_o      = (state != IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Timer outputs seen while the restart pulse is out are stale.
  assign live    = !timer_clear_o;
  assign prewait = stb_prewait_i && live;
  assign scllow  = stb_scllow_i && live;
  assign sclhigh = stb_sclhigh_i && live;
  assign ovf     = stb_overflow_i && live && busy_o;

  // A slave holding SCL low freezes the high-phase timing.
  assign stretch = ((state == BIT_HIGH) || (state == SP_SETUP))
                   && !scl_i;
  assign timer_run_o = busy_o && !stretch && !rst;

  // Sequencer state, line drivers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owned         <= 1'b0;
      is_write      <= 1'b0;
      wbit          <= 1'b0;
      scl_oe_o      <= 1'b0;
      sda_oe_o      <= 1'b0;
      timer_clear_o <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      arb_lost_o    <= 1'b0;
      rdata_o       <= 1'b0;
    end else begin
      timer_clear_o <= 1'b0;
      done_o        <= 1'b0;
      if (ovf) begin
        state    <= IDLE;
        scl_oe_o <= 1'b0;
        sda_oe_o <= 1'b0;
        owned    <= 1'b0;
        done_o   <= 1'b1;
        err_o    <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              err_o      <= 1'b0;
              arb_lost_o <= 1'b0;
              is_write   <= (cmd_i == CMD_WRITE);
              wbit       <= wdata_i;
              unique case (1'b1)
                (cmd_i == CMD_START) && !owned: begin
                  state         <= ST_HOLD;
                  sda_oe_o      <= 1'b1;
                  timer_clear_o <= 1'b1;
                end
                (cmd_i == CMD_START) && owned: begin
                  state         <= RS_REL;
                  sda_oe_o      <= 1'b0;
                  scl_oe_o      <= 1'b1;
                  timer_clear_o <= 1'b1;
                end
                (cmd_i != CMD_START) && !owned: begin
                  done_o <= 1'b1;
                  err_o  <= 1'b1;
                end
                (cmd_i == CMD_STOP) && owned: begin
                  state         <= SP_LOW;
                  sda_oe_o      <= 1'b1;
                  scl_oe_o      <= 1'b1;
                  timer_clear_o <= 1'b1;
                end
                default: begin
                  state         <= BIT_LOW;
                  sda_oe_o      <= (cmd_i == CMD_WRITE) && !wdata_i;
                  timer_clear_o <= 1'b1;
                end
              endcase
            end
          end
          RS_REL: begin
            if (scllow) begin
              state         <= RS_SETUP;
              scl_oe_o      <= 1'b0;
              timer_clear_o <= 1'b1;
            end
          end
          RS_SETUP: begin
            if (prewait && scl_i) begin
              state         <= ST_HOLD;
              sda_oe_o      <= 1'b1;
              timer_clear_o <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (prewait) begin
              state         <= ST_LOW;
              scl_oe_o      <= 1'b1;
              timer_clear_o <= 1'b1;
            end
          end
          ST_LOW: begin
            if (scllow) begin
              state  <= IDLE;
              owned  <= 1'b1;
              done_o <= 1'b1;
            end
          end
          BIT_LOW: begin
            if (scllow) begin
              state         <= BIT_HIGH;
              scl_oe_o      <= 1'b0;
              timer_clear_o <= 1'b1;
            end
          end
          BIT_HIGH: begin
            if (sclhigh && scl_i) begin
              state   <= IDLE;
              done_o  <= 1'b1;
              rdata_o <= sda_i;
              // The winning master owns the clock from here on.
              if (is_write && wbit && !sda_i) begin
                arb_lost_o <= 1'b1;
                owned      <= 1'b0;
                sda_oe_o   <= 1'b0;
                scl_oe_o   <= 1'b0;
              end else begin
                scl_oe_o <= 1'b1;
              end
            end
          end
          SP_LOW: begin
            if (scllow) begin
              state         <= SP_SETUP;
              scl_oe_o      <= 1'b0;
              timer_clear_o <= 1'b1;
            end
          end
          SP_SETUP: begin
            if (prewait && scl_i) begin
              state         <= SP_FREE;
              sda_oe_o      <= 1'b0;
              timer_clear_o <= 1'b1;
            end
          end
          SP_FREE: begin
            if (prewait) begin
              state  <= IDLE;
              owned  <= 1'b0;
              done_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_bitseq.sv
// Directed bench for the I2C bit sequencer with an ideal
// phase timer and open-drain bus model.
module tb_tqvp_dlmiles_i2c_bitseq;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic [1:0] cmd_i = 2'b00;
  logic       wdata_i = 1'b0;
  logic       cmd_ready_o, done_o, rdata_o, err_o;
  logic       arb_lost_o, busy_o;
  logic       timer_run_o, timer_clear_o;
  logic       scl_oe_o, sda_oe_o;
  logic       stb_prewait_i, stb_scllow_i;
  logic       stb_sclhigh_i, stb_overflow_i;
  logic       scl_i, sda_i;

  bit [7:0] tcnt = 8'd0;
  logic ovf_force = 1'b0;
  logic scl_hold = 1'b0;
  logic sda_force = 1'b0;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int scl_rise_cnt = 0;
  int done_cnt = 0;
  int sda_oe_cnt = 0;
  int sda_fall_cyc = 0;
  int scl_fall_cyc = 0;
  logic sda_at_rise = 1'b0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;

  logic got_err, got_arb, got_rdata;
  int lat = 0;
  int done_cyc = 0;

  always #5 clk = ~clk;

  assign stb_prewait_i  = (tcnt == 8'd6);
  assign stb_scllow_i   = (tcnt == 8'd9);
  assign stb_sclhigh_i  = (tcnt >= 8'd7);
  assign stb_overflow_i = ovf_force || (tcnt >= 8'd100);
  assign scl_i = !scl_oe_o && !scl_hold;
  assign sda_i = !sda_oe_o && !sda_force;

  tqvp_dlmiles_i2c_bitseq dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_i          (cmd_i),
    .wdata_i        (wdata_i),
    .done_o         (done_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .arb_lost_o     (arb_lost_o),
    .busy_o         (busy_o),
    .timer_run_o    (timer_run_o),
    .timer_clear_o  (timer_clear_o),
    .stb_prewait_i  (stb_prewait_i),
    .stb_scllow_i   (stb_scllow_i),
    .stb_sclhigh_i  (stb_sclhigh_i),
    .stb_overflow_i (stb_overflow_i),
    .scl_oe_o       (scl_oe_o),
    .sda_oe_o       (sda_oe_o),
    .scl_i          (scl_i),
    .sda_i          (sda_i)
  );

  // Ideal phase timer: cleared to 0, counts while enabled.
  always @(posedge clk) begin
    if (timer_clear_o === 1'b1)
      tcnt <= 8'd0;
    else if (timer_run_o === 1'b1 && tcnt != 8'hff)
      tcnt <= tcnt + 8'd1;
  end

  // Bus event monitor.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_scl <= scl_i;
    prev_sda <= sda_i;
    if (prev_sda === 1'b1 && sda_i === 1'b0) begin
      sda_fall_cyc <= cyc;
      if (prev_scl === 1'b1 && scl_i === 1'b1)
        start_cnt <= start_cnt + 1;
    end
    if (prev_sda === 1'b0 && sda_i === 1'b1 &&
        prev_scl === 1'b1 && scl_i === 1'b1)
      stop_cnt <= stop_cnt + 1;
    if (prev_scl === 1'b1 && scl_i === 1'b0)
      scl_fall_cyc <= cyc;
    if (prev_scl === 1'b0 && scl_i === 1'b1) begin
      scl_rise_cnt <= scl_rise_cnt + 1;
      sda_at_rise  <= sda_i;
    end
    if (done_o === 1'b1)
      done_cnt <= done_cnt + 1;
    if (sda_oe_o === 1'b1)
      sda_oe_cnt <= sda_oe_cnt + 1;
  end

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs,
                      input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic w);
    int n;
    @(negedge clk);
    chk1("ready", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    wdata_i     = w;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    n = 0;
    while (done_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1("done_seen", done_o, 1'b1);
    lat       = n;
    done_cyc  = cyc;
    got_err   = err_o;
    got_arb   = arb_lost_o;
    got_rdata = rdata_o;
    @(negedge clk);
    chk1("done_one_cycle", done_o, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3, n, bad, rel_cyc;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_ready", cmd_ready_o, 1'b0);
    chk1("rst_scl_oe", scl_oe_o, 1'b0);
    chk1("rst_sda_oe", sda_oe_o, 1'b0);
    chk1("rst_run", timer_run_o, 1'b0);
    chk1("rst_clear", timer_clear_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_arb", arb_lost_o, 1'b0);
    chk1("rst_rdata", rdata_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    rst = 1'b0;
    #1;
    chk1("ready_after_rst", cmd_ready_o, 1'b1);

    c0 = sda_oe_cnt;
    issue(CMD_STOP, 1'b0);
    chk1("stop_unowned_err", got_err, 1'b1);
    chki("stop_unowned_lat", lat, 0);
    chk1("stop_unowned_scl", scl_oe_o, 1'b0);
    chki("stop_unowned_sda_cnt", sda_oe_cnt - c0, 0);
    chk1("err_hold", err_o, 1'b1);
    issue(CMD_READ, 1'b0);
    chk1("read_unowned_err", got_err, 1'b1);

    c0 = done_cnt;
    c1 = start_cnt;
    c2 = scl_rise_cnt;
    c3 = stop_cnt;
    issue(CMD_START, 1'b0);
    chk1("start_err", got_err, 1'b0);
    chki("start_cond", start_cnt - c1, 1);
    chk1("start_order", sda_fall_cyc < scl_fall_cyc, 1'b1);
    chk1("start_scl_low", scl_oe_o, 1'b1);
    chk1("start_sda_low", sda_oe_o, 1'b1);
    issue(CMD_WRITE, 1'b1);
    chk1("w1_err", got_err, 1'b0);
    chk1("w1_arb", got_arb, 1'b0);
    chk1("w1_rdata", got_rdata, 1'b1);
    chki("w1_pulses", scl_rise_cnt - c2, 1);
    chk1("w1_sda_rel", sda_at_rise, 1'b1);
    chk1("w1_scl_held", scl_oe_o, 1'b1);
    chk1("w1_sda_oe", sda_oe_o, 1'b0);
    issue(CMD_STOP, 1'b0);
    chk1("stop_err", got_err, 1'b0);
    chki("stop_cond", stop_cnt - c3, 1);
    chk1("stop_scl_oe", scl_oe_o, 1'b0);
    chk1("stop_sda_oe", sda_oe_o, 1'b0);
    chki("seq_done_count", done_cnt - c0, 3);
    chki("seq_scl_pulses", scl_rise_cnt - c2, 2);

    issue(CMD_START, 1'b0);
    issue(CMD_WRITE, 1'b1);
    sda_force = 1'b1;
    c0 = sda_oe_cnt;
    issue(CMD_READ, 1'b0);
    chk1("read0_rdata", got_rdata, 1'b0);
    chk1("read0_err", got_err, 1'b0);
    chki("read0_sda_oe", sda_oe_cnt - c0, 0);
    sda_force = 1'b0;

    scl_hold = 1'b1;
    bad = 0;
    rel_cyc = 0;
    fork
      issue(CMD_READ, 1'b0);
      begin
        n = 0;
        @(negedge clk);
        while (scl_oe_o !== 1'b0 && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk1("stretch_enter", scl_oe_o, 1'b0);
        repeat (50) begin
          @(negedge clk);
          if (timer_run_o !== 1'b0) bad++;
        end
        chki("stretch_run_off", bad, 0);
        chk1("stretch_no_done", done_o, 1'b0);
        rel_cyc  = cyc;
        scl_hold = 1'b0;
      end
    join
    chk1("read1_rdata", got_rdata, 1'b1);
    chki("stretch_lat", done_cyc - rel_cyc, 8);

    sda_force = 1'b1;
    issue(CMD_WRITE, 1'b1);
    chk1("arb_lost", got_arb, 1'b1);
    chk1("arb_err", got_err, 1'b0);
    chk1("arb_sda_oe", sda_oe_o, 1'b0);
    chk1("arb_hold", arb_lost_o, 1'b1);
    sda_force = 1'b0;
    issue(CMD_WRITE, 1'b0);
    chk1("arb_then_err", got_err, 1'b1);
    chk1("arb_cleared", got_arb, 1'b0);

    issue(CMD_START, 1'b0);
    issue(CMD_WRITE, 1'b0);
    chk1("w0_rdata", got_rdata, 1'b0);
    c1 = start_cnt;
    c2 = scl_rise_cnt;
    issue(CMD_START, 1'b0);
    chk1("rs_err", got_err, 1'b0);
    chki("rs_start_cond", start_cnt - c1, 1);
    chki("rs_scl_pulse", scl_rise_cnt - c2, 1);
    chk1("rs_sda_high", sda_at_rise, 1'b1);
    issue(CMD_STOP, 1'b0);
    chk1("stop2_err", got_err, 1'b0);

    fork
      issue(CMD_START, 1'b0);
      begin
        n = 0;
        @(negedge clk);
        while (scl_oe_o !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        n = 0;
        while (stb_scllow_i !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        ovf_force = 1'b1;
        @(negedge clk);
        chk1("ovf_done", done_o, 1'b1);
        chk1("ovf_err", err_o, 1'b1);
        chk1("ovf_scl", scl_oe_o, 1'b0);
        chk1("ovf_sda", sda_oe_o, 1'b0);
        chk1("ovf_idle", cmd_ready_o, 1'b1);
        ovf_force = 1'b0;
      end
    join
    issue(CMD_WRITE, 1'b1);
    chk1("ovf_unowned", got_err, 1'b1);

    issue(CMD_START, 1'b0);
    c0 = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_i       = CMD_WRITE;
    wdata_i     = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk1("bitlow_busy", busy_o, 1'b1);
    chk1("bitlow_clear", timer_clear_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("mrst_ready", cmd_ready_o, 1'b0);
    chk1("mrst_scl", scl_oe_o, 1'b0);
    chk1("mrst_sda", sda_oe_o, 1'b0);
    chk1("mrst_done", done_o, 1'b0);
    chk1("mrst_run", timer_run_o, 1'b0);
    chk1("mrst_clear", timer_clear_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("mrst_ready_after", cmd_ready_o, 1'b1);
    chki("mrst_no_done", done_cnt - c0, 0);
    issue(CMD_WRITE, 1'b1);
    chk1("mrst_unowned", got_err, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
